// File: rtl/spi_xfer_ctrl.sv
// Master-mode SPI transfer sequencer: frames one 8-bit transfer per start,
// generates SCLK/SS and the per-edge sample/shift strobes for the shifter.
module spi_xfer_ctrl (
  input  logic       PCLK,
  input  logic       PRESET_i,
  input  logic       spe_i,
  input  logic       mstr_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic [2:0] sppr_i,
  input  logic [2:0] spr_i,
  input  logic       send_data_i,
  output logic       sclk_o,
  output logic       ss_o,
  output logic       tip_o,
  output logic       recieve_data_o,
  output logic       miso_recieve_sclk_o,
  output logic       miso_recieve_sclk0_o,
  output logic       mosi_send_sclk_o,
  output logic       mosi_send_sclk0_o
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t      state;
  logic [9:0]  cnt;
  logic [9:0]  hm1;
  logic [9:0]  hm1_l;
  logic [10:0] h_full;
  logic [3:0]  edge_idx;
  logic        cpol_l;
  logic        cpha_l;
  logic        pending;
  logic        start;
  logic        cnt_zero;
  logic        strobe;
  logic        rise;
  logic        sample;
  logic        shift;

  // Half-period H = (sppr+1) << spr spans 1..1024, so H-1 always fits 10 bits.
  assign h_full   = (11'(sppr_i) + 11'd1) << spr_i;
  assign hm1      = 10'(h_full - 11'd1);
  assign start    = spe_i & mstr_i & (send_data_i | pending);
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge PCLK or posedge PRESET_i) begin
    if (PRESET_i) begin
      state    <= IDLE;
      cnt      <= '0;
      hm1_l    <= '0;
      edge_idx <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      pending  <= 1'b0;
      ss_o     <= 1'b1;
      sclk_o   <= 1'b0;
      tip_o    <= 1'b0;
    end else if (!spe_i) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_idx <= '0;
      pending  <= 1'b0;
      ss_o     <= 1'b1;
      tip_o    <= 1'b0;
      sclk_o   <= cpol_i;
    end else begin
      if (state != IDLE && send_data_i)
        pending <= 1'b1;
      unique case (state)
        IDLE: begin
          sclk_o <= cpol_i;
          if (start) begin
            state    <= LEAD;
            cnt      <= hm1;
            hm1_l    <= hm1;
            edge_idx <= '0;
            cpol_l   <= cpol_i;
            cpha_l   <= cpha_i;
            pending  <= 1'b0;
            ss_o     <= 1'b0;
            tip_o    <= 1'b1;
          end
        end
        LEAD: begin
          sclk_o <= cpol_l;
          if (cnt_zero) begin
            state <= XFER;
            cnt   <= hm1_l;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XFER: begin
          if (cnt_zero) begin
            sclk_o   <= ~sclk_o;
            cnt      <= hm1_l;
            edge_idx <= edge_idx + 1'b1;
            if (edge_idx == 4'd15)
              state <= TRAIL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TRAIL: begin
          if (cnt_zero) begin
            state  <= IDLE;
            ss_o   <= 1'b1;
            tip_o  <= 1'b0;
            sclk_o <= cpol_i;
          end else begin
            sclk_o <= cpol_l;
            cnt    <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes fire in the cycle just before an SCLK edge; bit 7 is already on
  // MOSI at load for cpha=0, so the final shift strobe is dropped there.
  assign strobe = (state == XFER) & cnt_zero;
  assign rise   = ~sclk_o;
  assign sample = (edge_idx[0] == cpha_l);
  assign shift  = ~sample & ~(~cpha_l & (edge_idx == 4'd15));

  assign miso_recieve_sclk_o  = strobe & sample & rise;
  assign miso_recieve_sclk0_o = strobe & sample & ~rise;
  assign mosi_send_sclk_o     = strobe & shift & rise;
  assign mosi_send_sclk0_o    = strobe & shift & ~rise;
  assign recieve_data_o       = (state == TRAIL) & cnt_zero & spe_i;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a transfer-timeline model derived from H and elapsed time.
module tb_spi_xfer_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESET_i = 1'b1;
  logic       spe_i = 1'b0;
  logic       mstr_i = 1'b0;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic [2:0] sppr_i = 3'd0;
  logic [2:0] spr_i = 3'd0;
  logic       send_data_i = 1'b0;
  logic       sclk_o, ss_o, tip_o, recieve_data_o;
  logic       miso_recieve_sclk_o, miso_recieve_sclk0_o;
  logic       mosi_send_sclk_o, mosi_send_sclk0_o;

  always #5 PCLK = ~PCLK;

  spi_xfer_ctrl dut (
    .PCLK                 (PCLK),
    .PRESET_i             (PRESET_i),
    .spe_i                (spe_i),
    .mstr_i               (mstr_i),
    .cpol_i               (cpol_i),
    .cpha_i               (cpha_i),
    .sppr_i               (sppr_i),
    .spr_i                (spr_i),
    .send_data_i          (send_data_i),
    .sclk_o               (sclk_o),
    .ss_o                 (ss_o),
    .tip_o                (tip_o),
    .recieve_data_o       (recieve_data_o),
    .miso_recieve_sclk_o  (miso_recieve_sclk_o),
    .miso_recieve_sclk0_o (miso_recieve_sclk0_o),
    .mosi_send_sclk_o     (mosi_send_sclk_o),
    .mosi_send_sclk0_o    (mosi_send_sclk0_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a transfer is a timeline of 18*H cycles measured from the start edge.
  bit m_act = 0, m_pend = 0, m_idle_cpol = 0, m_cpol = 0, m_cpha = 0;
  int m_t = 0, m_h = 1;

  always @(posedge PCLK or posedge PRESET_i) begin
    if (PRESET_i) begin
      m_act = 0; m_pend = 0; m_idle_cpol = 0; m_t = 0;
    end else if (!spe_i) begin
      m_act = 0; m_pend = 0; m_idle_cpol = cpol_i;
    end else if (m_act) begin
      if (send_data_i) m_pend = 1;
      m_t++;
      if (m_t == 18 * m_h) begin
        m_act = 0;
        m_idle_cpol = cpol_i;
      end
    end else begin
      m_idle_cpol = cpol_i;
      if (mstr_i && (send_data_i || m_pend)) begin
        m_act = 1; m_t = 0; m_pend = 0;
        m_h = (int'(sppr_i) + 1) << spr_i;
        m_cpol = cpol_i; m_cpha = cpha_i;
      end
    end
  end

  always @(negedge PCLK) begin
    int n, e;
    logic sck, rcv, smp, rs, shf;
    logic [7:0] exp_v, act_v;
    sck = m_idle_cpol; rcv = 0; smp = 0; rs = 0; shf = 0; e = -1;
    if (m_act) begin
      // SCLK toggle j (0..15) takes effect at t = 2H + j*H
      n = (m_t < 2 * m_h) ? 0 : (m_t - 2 * m_h) / m_h + 1;
      if (n > 16) n = 16;
      sck = m_cpol ^ n[0];
      if (m_t + 1 >= 2 * m_h && ((m_t + 1 - 2 * m_h) % m_h) == 0)
        e = (m_t + 1 - 2 * m_h) / m_h;
      if (e > 15) e = -1;
      rcv = (m_t == 18 * m_h - 1) && spe_i;
      if (e >= 0) begin
        rs  = (sck == 1'b0);
        smp = ((e % 2) == int'(m_cpha));
        shf = !smp && !(m_cpha == 0 && e == 15);
      end
    end
    exp_v = {sck, !m_act, m_act, rcv, smp & rs, smp & !rs, shf & rs, shf & !rs};
    act_v = {sclk_o, ss_o, tip_o, recieve_data_o, miso_recieve_sclk_o,
             miso_recieve_sclk0_o, mosi_send_sclk_o, mosi_send_sclk0_o};
    check("cycle outputs", int'(act_v), int'(exp_v));
  end

  // Activity monitor for hand-computed per-scenario totals.
  int cyc = 0, ss_low, tog, miso_r, miso_f, mosi_r, mosi_f, recv_n, ss_falls;
  int gap, last_rise = 0, first_tog, last_tog;
  logic prev_ss = 1'b1, prev_sclk = 1'b0;

  always @(negedge PCLK) begin
    cyc++;
    if (!ss_o) ss_low++;
    if (!ss_o && sclk_o != prev_sclk) begin
      if (tog == 0) first_tog = cyc;
      last_tog = cyc;
      tog++;
    end
    if (prev_ss && !ss_o) begin ss_falls++; gap = cyc - last_rise; end
    if (!prev_ss && ss_o) last_rise = cyc;
    miso_r += int'(miso_recieve_sclk_o);
    miso_f += int'(miso_recieve_sclk0_o);
    mosi_r += int'(mosi_send_sclk_o);
    mosi_f += int'(mosi_send_sclk0_o);
    recv_n += int'(recieve_data_o);
    prev_ss = ss_o; prev_sclk = sclk_o;
  end

  task automatic clr();
    ss_low = 0; tog = 0; miso_r = 0; miso_f = 0; mosi_r = 0; mosi_f = 0;
    recv_n = 0; ss_falls = 0; gap = 0; first_tog = 0; last_tog = 0;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_send();
    send_data_i = 1'b1; step(); send_data_i = 1'b0;
  endtask

  task automatic cfg(input bit pol, input bit pha, input int pp, input int pr);
    cpol_i = pol; cpha_i = pha; sppr_i = 3'(pp); spr_i = 3'(pr);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int i = 0;
    while (tip_o && i < bound) begin step(); i++; end
    check(name, int'(i < bound), 1);
  endtask

  initial begin
    clr();
    step(3);
    check("reset ss", ss_o, 1);
    check("reset sclk", sclk_o, 0);
    check("reset tip", tip_o, 0);
    PRESET_i = 1'b0; spe_i = 1'b1; mstr_i = 1'b1;

    // Mode 0, H=1
    cfg(0, 0, 0, 0); step(2); clr();
    pulse_send(); wait_idle(100, "mode0 done"); step(2);
    check("mode0 ss_low", ss_low, 18);
    check("mode0 toggles", tog, 16);
    check("mode0 sclk span", last_tog - first_tog, 15);
    check("mode0 miso_r", miso_r, 8);
    check("mode0 mosi_f", mosi_f, 7);
    check("mode0 other strobes", miso_f + mosi_r, 0);
    check("mode0 recv", recv_n, 1);

    // Mode 3, H=4
    cfg(1, 1, 1, 1); step(2);
    check("mode3 idle sclk", sclk_o, 1);
    clr(); pulse_send(); wait_idle(200, "mode3 done"); step(2);
    check("mode3 ss_low", ss_low, 72);
    check("mode3 toggles", tog, 16);
    check("mode3 sclk span", last_tog - first_tog, 60);
    check("mode3 miso_r", miso_r, 8);
    check("mode3 mosi_f", mosi_f, 8);
    check("mode3 recv", recv_n, 1);

    // Pending: mode 1, H=2, extra requests near e=4 and e=6
    cfg(0, 1, 1, 0); step(2); clr();
    pulse_send(); step(10); pulse_send(); step(3); pulse_send();
    wait_idle(200, "pend first done"); step(3);
    wait_idle(200, "pend second done"); step(40);
    check("pend ss_falls", ss_falls, 2);
    check("pend ss gap", gap, 1);
    check("pend recv", recv_n, 2);
    check("pend ss_low", ss_low, 72);

    // Abort at e=5 with a request pending
    cfg(0, 0, 1, 0); step(2); clr();
    pulse_send(); step(3); pulse_send(); step(8);
    spe_i = 1'b0; step();
    check("abort ss", ss_o, 1);
    check("abort tip", tip_o, 0);
    step(3); spe_i = 1'b1; step(60);
    check("abort ss_falls", ss_falls, 1);
    check("abort recv", recv_n, 0);

    // Blocked start
    mstr_i = 1'b0; cfg(0, 0, 0, 0); step(2); clr();
    pulse_send(); step(10); mstr_i = 1'b1; step(20);
    check("blocked ss_falls", ss_falls, 0);
    check("blocked toggles", tog, 0);

    // Config change mid-transfer keeps latched H and polarity
    clr(); pulse_send(); step(5); cpol_i = 1'b1; spr_i = 3'd3;
    wait_idle(100, "cfgchg done"); step(2);
    check("cfgchg ss_low", ss_low, 18);
    check("cfgchg toggles", tog, 16);
    check("cfgchg recv", recv_n, 1);
    check("cfgchg idle sclk", sclk_o, 1);

    // Reset mid-XFER
    cfg(1, 0, 3, 0); step(2); pulse_send(); step(20);
    #2 PRESET_i = 1'b1;
    #1;
    check("midreset ss", ss_o, 1);
    check("midreset sclk", sclk_o, 0);
    check("midreset tip", tip_o, 0);
    step(2); PRESET_i = 1'b0; step();
    check("postreset sclk", sclk_o, 1);
    check("postreset ss", ss_o, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      send_data_i = ($urandom % 6 == 0);
      spe_i = ($urandom % 250 != 0);
      mstr_i = ($urandom % 20 != 0);
      if ($urandom % 40 == 0)
        cfg(1'($urandom), 1'($urandom), int'($urandom % 4), int'($urandom % 3));
      step();
    end
    send_data_i = 1'b0; spe_i = 1'b1; mstr_i = 1'b1;
    wait_idle(2000, "random drain");
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
